// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: decodes M-stage load/store controls, runs one
// outstanding req/ready/rvalid data-bus access, stalls until done, extends loads.
module lsu_mem #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  wr_en_M,
    input  logic [2:0]  rd_en_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic        stall_M,
    output logic [31:0] load_data_M,
    output logic        misalign_M,
    output logic        bus_err_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  ld_type_q, ld_type_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        bus_err_q, bus_err_d;

    logic        is_store, is_load, misaligned, access_ok;
    logic [1:0]  size;
    logic [3:0]  be;
    logic [31:0] wdata_lanes;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;

    // Access decode; a legal store code takes priority over any load code.
    always_comb begin
        is_store = 1'b0;
        is_load  = 1'b0;
        size     = 2'd0;
        case (wr_en_M)
            3'b001: begin is_store = 1'b1; size = 2'd0; end
            3'b010: begin is_store = 1'b1; size = 2'd1; end
            3'b011: begin is_store = 1'b1; size = 2'd2; end
            default: ;
        endcase
        if (!is_store) begin
            case (rd_en_M)
                3'b001, 3'b100: begin is_load = 1'b1; size = 2'd0; end
                3'b010, 3'b101: begin is_load = 1'b1; size = 2'd1; end
                3'b011:         begin is_load = 1'b1; size = 2'd2; end
                default: ;
            endcase
        end
        misaligned = (is_store || is_load) &&
                     (((size == 2'd1) && addr_M[0]) || ((size == 2'd2) && (addr_M[1:0] != 2'b00)));
        // Decode is ignored while in reset or during the bus-error release cycle.
        access_ok  = rst && (state_q == StIdle) && !bus_err_q &&
                     (is_store || is_load) && !misaligned;
        case (size)
            2'd0: begin
                be          = 4'b0001 << addr_M[1:0];
                wdata_lanes = {4{wdata_M[7:0]}};
            end
            2'd1: begin
                be          = 4'b0011 << addr_M[1:0];
                wdata_lanes = {2{wdata_M[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata_M;
            end
        endcase
    end

    assign misalign_M = rst && (state_q == StIdle) && !bus_err_q && misaligned;

    // Lane select and extension using the offset captured with the request.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_type_q)
            3'b001:  ext_data = {{24{rd_byte[7]}}, rd_byte};
            3'b010:  ext_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  ext_data = {24'd0, rd_byte};
            3'b101:  ext_data = {16'd0, rd_half};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        ld_type_d   = ld_type_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        load_d      = load_q;
        bus_err_d   = 1'b0;
        stall_M     = 1'b0;
        load_data_M = load_q;

        unique case (state_q)
            StIdle: begin
                if (access_ok) begin
                    stall_M     = 1'b1;
                    state_d     = StReq;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store;
                    mem_addr_d  = {addr_M[31:2], 2'b00};
                    mem_be_d    = be;
                    mem_wdata_d = is_store ? wdata_lanes : 32'd0;
                    ld_type_d   = rd_en_M;
                    off_d       = addr_M[1:0];
                    cnt_d       = 8'd0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_we_q ? StIdle : StWaitR;
                    cnt_d     = 8'd0;
                end else if (cnt_q == TimeoutLast) begin
                    stall_M   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) begin
                        load_d = 32'd0;
                    end
                end else begin
                    stall_M = 1'b1;
                end
            end
            StWaitR: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    state_d     = StIdle;
                    load_d      = ext_data;
                    load_data_M = ext_data;
                end else if (cnt_q == TimeoutLast) begin
                    stall_M   = 1'b1;
                    state_d   = StIdle;
                    bus_err_d = 1'b1;
                    load_d    = 32'd0;
                end else begin
                    stall_M = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            ld_type_q   <= 3'd0;
            off_q       <= 2'd0;
            cnt_q       <= 8'd0;
            load_q      <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            ld_type_q   <= ld_type_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            load_q      <= load_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err_M = bus_err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: driver issues accesses and acts as the bus slave, a
// negedge monitor checks bus requests, load returns and error pulses from queues.
module tb_lsu_mem;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  wr_en_M;
    logic [2:0]  rd_en_M;
    logic [31:0] addr_M;
    logic [31:0] wdata_M;
    logic        stall_M;
    logic [31:0] load_data_M;
    logic        misalign_M;
    logic        bus_err_M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_mem #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en_M     (wr_en_M),
        .rd_en_M     (rd_en_M),
        .addr_M      (addr_M),
        .wdata_M     (wdata_M),
        .stall_M     (stall_M),
        .load_data_M (load_data_M),
        .misalign_M  (misalign_M),
        .bus_err_M   (bus_err_M),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] err_q[$];
    logic [31:0] last_load;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode: n = access bytes (0 = no access), st = store, sgn = sign-extend.
    function automatic void decode(input logic [2:0] wr, input logic [2:0] rd,
                                   output bit st, output int n, output bit sgn);
        st  = 1'b0;
        n   = 0;
        sgn = 1'b0;
        if (wr >= 3'd1 && wr <= 3'd3) begin
            st = 1'b1;
            n  = 1 << (int'(wr) - 1);
        end else if (rd >= 3'd1 && rd <= 3'd3) begin
            n   = 1 << (int'(rd) - 1);
            sgn = (rd != 3'd3);
        end else if (rd == 3'd4 || rd == 3'd5) begin
            n = 1 << (int'(rd) - 4);
        end
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] w, input int off,
                                             input int n, input bit sgn);
        logic [31:0] v;
        logic [31:0] m;
        if (n == 4) return w;
        m = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (w >> (8 * off)) & m;
        if (sgn && ((v & ((m >> 1) + 32'd1)) != 32'd0)) v = v | ~m;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (mem_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req), 32'd0);
                end else begin
                    chk("req_we", 32'(mem_we), 32'(req_q[0].we));
                    chk("req_addr", mem_addr, req_q[0].addr);
                    chk("req_be", 32'(mem_be), 32'(req_q[0].be));
                    if (req_q[0].we) chk("req_wdata", mem_wdata, req_q[0].wdata);
                    if (mem_ready) void'(req_q.pop_front());
                end
            end
            if (mem_rvalid) begin
                if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(mem_rvalid), 32'd0);
                else chk("load_data", load_data_M, rsp_q.pop_front());
            end
            if (bus_err_M) begin
                if (err_q.size() == 0) chk("unexpected_err", 32'(bus_err_M), 32'd0);
                else chk("err_load_data", load_data_M, err_q.pop_front());
            end
        end
    end

    task automatic run_access(input logic [2:0] wr, input logic [2:0] rd, input logic [31:0] a,
                              input logic [31:0] d, input int rdy_dly, input int rv_dly,
                              input logic [31:0] rdata);
        bit          st;
        bit          sgn;
        bit          mis;
        int          n;
        int          off;
        req_t        r;
        logic [31:0] exp_ld;
        decode(wr, rd, st, n, sgn);
        off = int'(a[1:0]);
        mis = (n != 0) && ((off % n) != 0);
        @(posedge clk);
        #1;
        chk("queues_drained", 32'(req_q.size() + rsp_q.size() + err_q.size()), 32'd0);
        req_q.delete();
        rsp_q.delete();
        err_q.delete();
        wr_en_M    = wr;
        rd_en_M    = rd;
        addr_M     = a;
        wdata_M    = d;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        exp_ld     = ext_load(rdata, off, n, sgn);
        if (n != 0 && !mis) begin
            r.we    = st;
            r.addr  = {a[31:2], 2'b00};
            r.be    = 4'(((1 << n) - 1) << off);
            r.wdata = (n == 1) ? {24'd0, d[7:0]} * 32'h0101_0101 :
                      (n == 2) ? {16'd0, d[15:0]} * 32'h0001_0001 : d;
            req_q.push_back(r);
            if (rdy_dly >= TMO)     err_q.push_back(st ? last_load : 32'd0);
            else if (st)            ;
            else if (rv_dly >= TMO) err_q.push_back(32'd0);
            else                    rsp_q.push_back(exp_ld);
        end
        @(negedge clk);
        chk("idle_stall", 32'(stall_M), 32'(n != 0 && !mis));
        chk("misalign", 32'(misalign_M), 32'(mis));
        chk("idle_load_hold", load_data_M, last_load);
        chk("idle_no_req", 32'(mem_req), 32'd0);
        if (n == 0 || mis) return;
        for (int i = 0; i < TMO; i++) begin
            @(posedge clk);
            #1;
            mem_ready = (i == rdy_dly);
            @(negedge clk);
            chk("req_stall", 32'(stall_M), 32'(i != rdy_dly));
            if (i == rdy_dly) break;
        end
        if (rdy_dly >= TMO) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("timeout_err", 32'(bus_err_M), 32'd1);
            chk("timeout_stall", 32'(stall_M), 32'd0);
            chk("timeout_req", 32'(mem_req), 32'd0);
            if (req_q.size() != 0) void'(req_q.pop_front());
            if (!st) last_load = 32'd0;
            return;
        end
        if (st) return;
        for (int j = 0; j < TMO; j++) begin
            @(posedge clk);
            #1;
            mem_ready  = 1'b0;
            mem_rvalid = (j == rv_dly);
            mem_rdata  = (j == rv_dly) ? rdata : $urandom;
            @(negedge clk);
            chk("wait_stall", 32'(stall_M), 32'(j != rv_dly));
            if (j == rv_dly) break;
        end
        if (rv_dly >= TMO) begin
            @(posedge clk);
            #1;
            mem_rdata = $urandom;
            @(negedge clk);
            chk("timeout_err", 32'(bus_err_M), 32'd1);
            chk("timeout_stall", 32'(stall_M), 32'd0);
            last_load = 32'd0;
            return;
        end
        last_load = exp_ld;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  wr;
        logic [2:0]  rd;
        logic [31:0] a;
        int          sel;
        int          rdy;
        int          rv;
        checks     = 0;
        errors     = 0;
        last_load  = 32'd0;
        rst        = 1'b0;
        wr_en_M    = 3'd0;
        rd_en_M    = 3'd0;
        addr_M     = 32'd0;
        wdata_M    = 32'd0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_load", load_data_M, 32'd0);
        chk("rst_err", 32'(bus_err_M), 32'd0);
        chk("rst_stall", 32'(stall_M), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_access(3'd3, 3'd0, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'd0);
        run_access(3'd1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0);
        run_access(3'd0, 3'd1, 32'h0000_2002, 32'd0, 0, 1, 32'h0080_FF00);
        run_access(3'd0, 3'd4, 32'h0000_2002, 32'd0, 0, 1, 32'h0080_FF00);
        run_access(3'd0, 3'd2, 32'h0000_2002, 32'd0, 0, 1, 32'h0080_FF00);
        run_access(3'd0, 3'd3, 32'h0000_2001, 32'd0, 0, 0, 32'd0);
        run_access(3'd0, 3'd3, 32'h0000_2004, 32'd0, 3, 0, 32'h1234_5678);
        run_access(3'd0, 3'd5, 32'h0000_2006, 32'd0, 0, TMO + 2, 32'hFFFF_0000);
        run_access(3'd2, 3'd0, 32'h0000_2006, 32'h0000_BEEF, TMO + 1, 0, 32'd0);
        run_access(3'd2, 3'd3, 32'h0000_300A, 32'h0000_1234, 1, 0, 32'd0);

        // Reset while a load is waiting for read data.
        @(posedge clk);
        #1;
        wr_en_M = 3'd0;
        rd_en_M = 3'd3;
        addr_M  = 32'h0000_3000;
        req_q.delete();
        rsp_q.delete();
        err_q.delete();
        req_q.push_back('{1'b0, 32'h0000_3000, 4'hF, 32'd0});
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("prerst_stall", 32'(stall_M), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(stall_M), 32'd0);
        chk("midrst_load", load_data_M, 32'd0);
        rd_en_M = 3'd0;
        last_load = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_access(3'd2, 3'd0, 32'h0000_4002, 32'h0000_CAFE, 1, 0, 32'd0);

        for (int k = 0; k < 250; k++) begin
            sel = int'($urandom_range(0, 9));
            wr  = 3'd0;
            rd  = 3'd0;
            if (sel < 4)      wr = 3'($urandom_range(1, 3));
            else if (sel < 9) rd = 3'($urandom_range(1, 5));
            else begin
                wr = 3'($urandom_range(0, 7));
                rd = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            rdy = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, TMO - 1));
            rv  = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, TMO - 1));
            run_access(wr, rd, a, $urandom, rdy, rv, $urandom);
        end
        @(posedge clk);
        #1;
        chk("final_drained", 32'(req_q.size() + rsp_q.size() + err_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
